bitsel_reader: RTL and testbench

Pipelined reader for a 1024-bit bit-addressable vector. It is the read-side counterpart of the bit-select writer blocks: it snapshots a 1024-bit vector, accepts indexed read requests (10-bit bit offset plus 4-bit nibble mask) over a valid/ready handshake, and returns the 16-bit window in request order. It sits between the vector-state owner and any consumer that needs arbitrary unaligned 16-bit field extraction at one read per cycle.

---
 rtl/bitsel_reader_if.sv | 27 ++
 rtl/bitsel_reader.sv | 115 +++++++++++
 tb/tb_bitsel_reader.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitsel_reader_if.sv
// Handshake bundle for the bit-select reader: snapshot load port,
// indexed read request channel, response channel and a busy flag.
interface bitsel_reader_if;
    logic [1023:0] vec;
    logic          load;
    logic          load_ready;
    logic          req_valid;
    logic          req_ready;
    logic [9:0]    req_ctrl;
    logic [3:0]    req_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_data;
    logic          busy;

    // Consumer side: issues loads and read requests, accepts responses.
    modport master (
        output vec, load, req_valid, req_ctrl, req_sel, rsp_ready,
        input  load_ready, req_ready, rsp_valid, rsp_data, busy
    );

    // Reader side: owns the shadow vector and the two pipeline stages.
    modport slave (
        input  vec, load, req_valid, req_ctrl, req_sel, rsp_ready,
        output load_ready, req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/bitsel_reader.sv
// Two-stage pipelined reader of a 1024-bit shadow vector. Stage 1 holds the
// accepted request (offset + nibble mask); the 16-bit window is extracted from
// the shadow while moving into stage 2, which holds the registered response.
// The shadow may only be reloaded while stage 1 is empty, so a request always
// reads the vector that was current when it was accepted (or loaded on the
// same edge).
module bitsel_reader #(
    parameter bit WRAP = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    bitsel_reader_if.slave     bus
);

    logic [1023:0] shadow_q,   shadow_d;
    logic          s1_valid_q, s1_valid_d;
    logic [9:0]    s1_ctrl_q,  s1_ctrl_d;
    logic [3:0]    s1_sel_q,   s1_sel_d;
    logic          s2_valid_q, s2_valid_d;
    logic [15:0]   rsp_data_q, rsp_data_d;

    logic          s2_free;
    logic          s1_advance;
    logic          req_fire;
    logic          load_fire;
    logic [15:0]   raw_window;
    logic [15:0]   masked_window;

    // Handshake decode: stage 2 can take new data when empty or draining,
    // and stage 1 can take a request when empty or moving forward itself.
    always_comb begin
        s2_free        = !s2_valid_q || bus.rsp_ready;
        s1_advance     = s1_valid_q && s2_free;
        bus.req_ready  = !s1_valid_q || s2_free;
        bus.load_ready = !s1_valid_q;
        req_fire       = bus.req_valid && bus.req_ready;
        load_fire      = bus.load && bus.load_ready;
    end

    // Extract the 16-bit window starting at s1_ctrl, wrapping or zero-filling
    // past the top bit, then blank the nibbles not enabled by s1_sel.
    always_comb begin
        logic [10:0] idx;
        raw_window    = '0;
        masked_window = '0;
        idx           = '0;
        for (int k = 0; k < 16; k++) begin
            idx = {1'b0, s1_ctrl_q} + 11'(k);
            if (WRAP || !idx[10]) begin
                raw_window[k] = shadow_q[idx[9:0]];
            end
        end
        for (int n = 0; n < 4; n++) begin
            if (s1_sel_q[n]) begin
                masked_window[4*n +: 4] = raw_window[4*n +: 4];
            end
        end
    end

    // Next-state for the shadow and both pipeline stages.
    always_comb begin
        shadow_d   = shadow_q;
        s1_valid_d = s1_valid_q;
        s1_ctrl_d  = s1_ctrl_q;
        s1_sel_d   = s1_sel_q;
        s2_valid_d = s2_valid_q;
        rsp_data_d = rsp_data_q;

        if (load_fire) begin
            shadow_d = bus.vec;
        end

        if (req_fire) begin
            s1_valid_d = 1'b1;
            s1_ctrl_d  = bus.req_ctrl;
            s1_sel_d   = bus.req_sel;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (s1_advance) begin
            s2_valid_d = 1'b1;
            rsp_data_d = masked_window;
        end else if (bus.rsp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_ctrl_q  <= '0;
            s1_sel_q   <= '0;
            s2_valid_q <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            s1_valid_q <= s1_valid_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s1_sel_q   <= s1_sel_d;
            s2_valid_q <= s2_valid_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Response and status outputs come straight from the registers.
    always_comb begin
        bus.rsp_valid = s2_valid_q;
        bus.rsp_data  = rsp_data_q;
        bus.busy      = s1_valid_q | s2_valid_q;
    end

endmodule

// File: tb/tb_bitsel_reader.sv
// Directed bench for bitsel_reader. A WRAP=1 instance is the main device;
// a WRAP=0 instance shares its inputs so the zero-fill behaviour past bit
// 1023 can be compared on the same requests.
module tb_bitsel_reader;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    logic [1023:0] vec_a;
    logic [1023:0] vec_b;

    bitsel_reader_if bus ();
    bitsel_reader_if bus_nw ();

    bitsel_reader #(.WRAP(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    bitsel_reader #(.WRAP(1'b0)) dut_nw (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_nw)
    );

    // The zero-fill instance mirrors every input of the main instance.
    assign bus_nw.vec       = bus.vec;
    assign bus_nw.load      = bus.load;
    assign bus_nw.req_valid = bus.req_valid;
    assign bus_nw.req_ctrl  = bus.req_ctrl;
    assign bus_nw.req_sel   = bus.req_sel;
    assign bus_nw.rsp_ready = bus.rsp_ready;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec(input logic [1023:0] v);
        bus.vec  = v;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_data !== 16'h0000) begin
            errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0000", bus.rsp_data);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        end
        checks++;
        if (bus.req_ready !== 1'b1 || bus.load_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready: got req_ready=%b load_ready=%b expected 1/1",
                               bus.req_ready, bus.load_ready);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_vec(vec_a);
        bus.req_valid = 1'b1;
        bus.req_ctrl  = 10'd0;
        bus.req_sel   = 4'hF;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_req_ready: got %b expected 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_latency_early: got rsp_valid=%b busy=%b expected 0/1",
                               bus.rsp_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hBEEF) begin
            errors++; $display("[TB] FAIL basic_rsp: got valid=%b data=%h expected 1/BEEF",
                               bus.rsp_valid, bus.rsp_data);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_drain: got rsp_valid=%b busy=%b expected 0/0",
                               bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  ctrl_tab [3];
        logic [3:0]  sel_tab  [3];
        logic [15:0] exp_tab  [3];
        ctrl_tab = '{10'd4, 10'd0, 10'd16};
        sel_tab  = '{4'hF, 4'b0101, 4'hF};
        exp_tab  = '{16'h4BEE, 16'h0E0F, 16'h1234};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                bus.req_valid = 1'b1;
                bus.req_ctrl  = ctrl_tab[i];
                bus.req_sel   = sel_tab[i];
                checks++;
                if (bus.req_ready !== 1'b1) begin
                    errors++; $display("[TB] FAIL b2b_req_ready[%0d]: got %b expected 1", i, bus.req_ready);
                end
            end else begin
                bus.req_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 3) begin
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_tab[i-1]) begin
                    errors++; $display("[TB] FAIL b2b_rsp[%0d]: got valid=%b data=%h expected 1/%h",
                                       i - 1, bus.rsp_valid, bus.rsp_data, exp_tab[i-1]);
                end
            end
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_drain: got rsp_valid=%b expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_wrap();
        bus.req_valid = 1'b1;
        bus.req_ctrl  = 10'd1016;
        bus.req_sel   = 4'hF;
        tick();
        bus.req_ctrl  = 10'd1023;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_data !== 16'hEFCA || bus_nw.rsp_data !== 16'h00CA) begin
            errors++; $display("[TB] FAIL wrap_1016: got wrap=%h zero=%h expected EFCA/00CA",
                               bus.rsp_data, bus_nw.rsp_data);
        end
        tick();
        checks++;
        if (bus.rsp_data !== 16'h7DDF || bus_nw.rsp_data !== 16'h0001) begin
            errors++; $display("[TB] FAIL wrap_1023: got wrap=%h zero=%h expected 7DDF/0001",
                               bus.rsp_data, bus_nw.rsp_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_ctrl  = 10'd0;
        bus.req_sel   = 4'hF;
        tick();
        bus.req_ctrl  = 10'd4;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_second_ready: got %b expected 1", bus.req_ready);
        end
        tick();
        bus.req_ctrl  = 10'd16;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_full_ready: got %b expected 0", bus.req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hBEEF || bus.req_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h req_ready=%b expected 1/BEEF/0",
                                   i, bus.rsp_valid, bus.rsp_data, bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release_ready: got %b expected 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h4BEE) begin
            errors++; $display("[TB] FAIL bp_rsp1: got valid=%b data=%h expected 1/4BEE",
                               bus.rsp_valid, bus.rsp_data);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h1234) begin
            errors++; $display("[TB] FAIL bp_rsp2: got valid=%b data=%h expected 1/1234",
                               bus.rsp_valid, bus.rsp_data);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_drain: got rsp_valid=%b busy=%b expected 0/0",
                               bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_load_interlock();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_ctrl  = 10'd0;
        bus.req_sel   = 4'hF;
        tick();
        bus.req_ctrl  = 10'd16;
        tick();
        bus.req_valid = 1'b0;
        bus.vec       = vec_b;
        bus.load      = 1'b1;
        #1;
        checks++;
        if (bus.load_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL lock_load_ready: got %b expected 0", bus.load_ready);
        end
        tick();
        checks++;
        if (bus.load_ready !== 1'b0 || bus.rsp_data !== 16'hBEEF) begin
            errors++; $display("[TB] FAIL lock_hold: got load_ready=%b data=%h expected 0/BEEF",
                               bus.load_ready, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h1234) begin
            errors++; $display("[TB] FAIL lock_old_data: got valid=%b data=%h expected 1/1234",
                               bus.rsp_valid, bus.rsp_data);
        end
        checks++;
        if (bus.load_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL lock_load_free: got %b expected 1", bus.load_ready);
        end
        tick();
        bus.load      = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_ctrl  = 10'd16;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hC3C3) begin
            errors++; $display("[TB] FAIL lock_new_data: got valid=%b data=%h expected 1/C3C3",
                               bus.rsp_valid, bus.rsp_data);
        end
        tick();
    endtask

    task automatic test_simul_load();
        bus.vec       = vec_a;
        bus.load      = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_ctrl  = 10'd0;
        bus.req_sel   = 4'hF;
        tick();
        bus.load      = 1'b0;
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hBEEF) begin
            errors++; $display("[TB] FAIL simul_load: got valid=%b data=%h expected 1/BEEF",
                               bus.rsp_valid, bus.rsp_data);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_ctrl  = 10'd0;
        bus.req_sel   = 4'hF;
        tick();
        bus.req_ctrl  = 10'd4;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_full: got busy=%b req_ready=%b expected 1/0",
                               bus.busy, bus.req_ready);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h0000) begin
            errors++; $display("[TB] FAIL mid_reset: got busy=%b valid=%b data=%h expected 0/0/0000",
                               bus.busy, bus.rsp_valid, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL mid_stale[%0d]: got rsp_valid=%b expected 0", i, bus.rsp_valid);
            end
        end
        bus.req_valid = 1'b1;
        bus.req_ctrl  = 10'd0;
        bus.req_sel   = 4'hF;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0000) begin
            errors++; $display("[TB] FAIL mid_cleared_shadow: got valid=%b data=%h expected 1/0000",
                               bus.rsp_valid, bus.rsp_data);
        end
        tick();
    endtask

    // Test sequence.
    initial begin
        checks = 0;
        errors = 0;
        vec_a = '0;
        vec_a[15:0]      = 16'hBEEF;
        vec_a[31:16]     = 16'h1234;
        vec_a[1023:1008] = 16'hCAFE;
        vec_b = '0;
        vec_b[15:0]      = 16'h5A5A;
        vec_b[31:16]     = 16'hC3C3;

        resetn        = 1'b0;
        bus.vec       = '0;
        bus.load      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_ctrl  = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b1;

        $display("[TB] starting bitsel_reader tests");
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_load_interlock();
        test_simul_load();
        test_reset_midflight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
